// File: rtl/bkg_pkg.sv
// bkg_pkg: shared types and helpers for background-RAM consumers.
package bkg_pkg;

    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } sample_pair_t;

    function automatic logic [15:0] sat_sub16(input logic [15:0] d, input logic [15:0] b);
        return (d >= b) ? d - b : '0;
    endfunction

endpackage

// File: rtl/bkg_align_pipe.sv
// bkg_align_pipe: delays data/valid/sop by LAT clocks to line up with the background RAM read.
module bkg_align_pipe #(
    parameter int LAT = 1
) (
    input  logic        clk_clk,
    input  logic        rst_reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sop
);

    logic [LAT-1:0][31:0] d_q;
    logic [LAT-1:0]       v_q;
    logic [LAT-1:0]       s_q;

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            d_q <= '0;
            v_q <= '0;
            s_q <= '0;
        end else begin
            d_q[0] <= in_data;
            v_q[0] <= in_valid;
            s_q[0] <= in_valid && in_sop;
            for (int i = 1; i < LAT; i++) begin
                d_q[i] <= d_q[i-1];
                v_q[i] <= v_q[i-1];
                s_q[i] <= s_q[i-1];
            end
        end
    end

    assign out_data  = d_q[LAT-1];
    assign out_valid = v_q[LAT-1];
    assign out_sop   = s_q[LAT-1];

endmodule

// File: rtl/bkg_subtract.sv
// bkg_subtract: walks the background RAM address per frame and subtracts the aligned
// background from each 16-bit half, clamping at zero and counting clamp events.
module bkg_subtract
    import bkg_pkg::*;
#(
    parameter int N_WORDS = 128,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_clk,
    input  logic              rst_reset,
    input  logic              enable,
    input  logic [31:0]       data_in_data,
    input  logic              data_in_valid,
    input  logic              data_in_sop,
    output logic [ADDR_W-1:0] address,
    input  logic [31:0]       bkg_signal,
    input  logic              bkg_sub_status,
    output logic [31:0]       data_out_data,
    output logic              data_out_valid,
    output logic              data_out_sop,
    output logic              sub_active,
    output logic [15:0]       clip_count_last,
    output logic              frame_overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

    logic [ADDR_W-1:0] wcnt;
    logic              wrapped;
    logic [31:0]       p_data;
    logic              p_valid;
    logic              p_sop;
    sample_pair_t      d;
    sample_pair_t      b;
    sample_pair_t      s;
    logic              act;
    logic              clip_hi;
    logic              clip_lo;
    logic [1:0]        n_clip;
    logic [16:0]       clip_sum;
    logic [15:0]       clip_next;
    logic [15:0]       clip_cnt;

    // sop always restarts the frame, so it also beats a pending wrap
    assign address = (data_in_valid && data_in_sop) ? '0 : wcnt;

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            wcnt          <= '0;
            wrapped       <= 1'b0;
            frame_overrun <= 1'b0;
        end else if (data_in_valid) begin
            wcnt    <= (address == LAST) ? '0 : address + 1'b1;
            wrapped <= (address == LAST);
            if (!data_in_sop && wrapped)
                frame_overrun <= 1'b1;
        end
    end

    bkg_align_pipe #(
        .LAT(RAM_LAT)
    ) u_pipe (
        .clk_clk  (clk_clk),
        .rst_reset(rst_reset),
        .in_data  (data_in_data),
        .in_valid (data_in_valid),
        .in_sop   (data_in_sop),
        .out_data (p_data),
        .out_valid(p_valid),
        .out_sop  (p_sop)
    );

    assign d         = p_data;
    assign b         = bkg_signal;
    assign act       = enable && bkg_sub_status;
    assign clip_hi   = act && (d.hi < b.hi);
    assign clip_lo   = act && (d.lo < b.lo);
    assign n_clip    = {1'b0, clip_hi} + {1'b0, clip_lo};
    assign clip_sum  = {1'b0, clip_cnt} + 17'(n_clip);
    assign clip_next = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    assign s.hi      = act ? sat_sub16(d.hi, b.hi) : d.hi;
    assign s.lo      = act ? sat_sub16(d.lo, b.lo) : d.lo;

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            data_out_data   <= '0;
            data_out_valid  <= 1'b0;
            data_out_sop    <= 1'b0;
            sub_active      <= 1'b0;
            clip_cnt        <= '0;
            clip_count_last <= '0;
        end else begin
            data_out_valid <= p_valid;
            data_out_sop   <= p_valid && p_sop;
            sub_active     <= p_valid && act;
            if (p_valid) begin
                data_out_data <= s;
                if (p_sop) begin
                    clip_count_last <= clip_cnt;
                    clip_cnt        <= {14'd0, n_clip};
                end else begin
                    clip_cnt <= clip_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bkg_subtract.sv
// tb_bkg_subtract: directed vectors for bkg_subtract with N_WORDS=4, RAM_LAT=1.
module tb_bkg_subtract;

    logic        clk_clk = 1'b0;
    logic        rst_reset;
    logic        enable;
    logic [31:0] data_in_data;
    logic        data_in_valid;
    logic        data_in_sop;
    logic [7:0]  address;
    logic [31:0] bkg_signal = '0;
    logic        bkg_sub_status;
    logic [31:0] data_out_data;
    logic        data_out_valid;
    logic        data_out_sop;
    logic        sub_active;
    logic [15:0] clip_count_last;
    logic        frame_overrun;

    logic [31:0] bkg_mem [4];
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        logic        en;
        logic        st;
        logic [31:0] bkg;
        logic [31:0] din;
        logic [31:0] exp;
        logic        act;
        logic [15:0] last;
    } vec_t;

    vec_t tv [8];

    bkg_subtract #(
        .N_WORDS(4),
        .RAM_LAT(1)
    ) dut (
        .clk_clk        (clk_clk),
        .rst_reset      (rst_reset),
        .enable         (enable),
        .data_in_data   (data_in_data),
        .data_in_valid  (data_in_valid),
        .data_in_sop    (data_in_sop),
        .address        (address),
        .bkg_signal     (bkg_signal),
        .bkg_sub_status (bkg_sub_status),
        .data_out_data  (data_out_data),
        .data_out_valid (data_out_valid),
        .data_out_sop   (data_out_sop),
        .sub_active     (sub_active),
        .clip_count_last(clip_count_last),
        .frame_overrun  (frame_overrun)
    );

    always #5 clk_clk = ~clk_clk;

    // one-clock read latency background RAM
    always @(posedge clk_clk) bkg_signal <= bkg_mem[address[1:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // one isolated word: check address on input cycle, output RAM_LAT+1 clocks later
    task automatic word(input logic [31:0] din, input logic sop, input logic [7:0] exp_addr,
                        input logic [31:0] exp_out, input logic exp_act);
        data_in_data  = din;
        data_in_sop   = sop;
        data_in_valid = 1'b1;
        #1 chk("address", address, exp_addr);
        @(posedge clk_clk);
        #1 data_in_valid = 1'b0;
        data_in_sop = 1'b0;
        chk("valid_gap", data_out_valid, 0);
        @(posedge clk_clk);
        #1 chk("out_valid", data_out_valid, 1);
        chk("out_data", data_out_data, exp_out);
        chk("sub_active", sub_active, exp_act);
        chk("out_sop", data_out_sop, sop);
    endtask

    task automatic chk_all_zero();
        chk("rst_data", data_out_data, 0);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_sop", data_out_sop, 0);
        chk("rst_active", sub_active, 0);
        chk("rst_clip_last", clip_count_last, 0);
        chk("rst_overrun", frame_overrun, 0);
        chk("rst_address", address, 0);
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 32'h0010_0020, 32'h0100_0200, 32'h0100_0200, 1'b0, 16'd0};
        tv[1] = '{1'b1, 1'b1, 32'h0010_0020, 32'h0100_0200, 32'h00F0_01E0, 1'b1, 16'd0};
        tv[2] = '{1'b1, 1'b1, 32'h0300_0005, 32'h0100_0004, 32'h0000_0000, 1'b1, 16'd0};
        tv[3] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1, 16'd2};
        tv[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0001_0002, 32'h0001_0002, 1'b0, 16'd0};
        tv[5] = '{1'b1, 1'b1, 32'h1000_0000, 32'h0FFF_FFFF, 32'h0000_FFFF, 1'b1, 16'd0};
        tv[6] = '{1'b1, 1'b1, 32'h8000_8000, 32'h8000_8000, 32'h0000_0000, 1'b1, 16'd1};
        tv[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hABCD_EF01, 32'hABCD_EF01, 1'b0, 16'd0};

        rst_reset = 1'b1;
        enable = 1'b1;
        bkg_sub_status = 1'b0;
        data_in_data = '0;
        data_in_valid = 1'b0;
        data_in_sop = 1'b0;
        for (int i = 0; i < 4; i++) bkg_mem[i] = '0;
        repeat (2) @(posedge clk_clk);
        #1 chk_all_zero();
        rst_reset = 1'b0;
        @(posedge clk_clk);
        #1;

        // single-word frames; clip_count_last reports the previous vector's clamps
        for (int i = 0; i < 8; i++) begin
            enable = tv[i].en;
            bkg_sub_status = tv[i].st;
            bkg_mem[0] = tv[i].bkg;
            word(tv[i].din, 1'b1, 8'd0, tv[i].exp, tv[i].act);
            chk($sformatf("clip_last_v%0d", i), clip_count_last, tv[i].last);
        end
        chk("no_overrun_sops", frame_overrun, 0);

        // frame walk over 4 words, then an overrun word
        enable = 1'b1;
        bkg_sub_status = 1'b1;
        bkg_mem[0] = 32'h0002_0000;
        bkg_mem[1] = 32'h0005_0005;
        bkg_mem[2] = 32'h0020_0020;
        bkg_mem[3] = 32'h0010_0001;
        word(32'h0001_0001, 1'b1, 8'd0, 32'h0000_0001, 1'b1);
        enable = 1'b0;
        word(32'h0001_0001, 1'b0, 8'd1, 32'h0001_0001, 1'b0);
        enable = 1'b1;
        word(32'h0010_0010, 1'b0, 8'd2, 32'h0000_0000, 1'b1);
        word(32'h0030_0030, 1'b0, 8'd3, 32'h0020_002F, 1'b1);
        chk("overrun_before", frame_overrun, 0);
        word(32'h0003_0003, 1'b0, 8'd0, 32'h0001_0003, 1'b1);
        chk("overrun_set", frame_overrun, 1);
        word(32'h0000_0000, 1'b1, 8'd0, 32'h0000_0000, 1'b1);
        chk("clip_last_frame", clip_count_last, 3);
        chk("overrun_sticky", frame_overrun, 1);

        // reset while word 2 of a frame is in flight
        word(32'h0005_0005, 1'b1, 8'd0, 32'h0003_0005, 1'b1);
        chk("clip_last_pre_rst", clip_count_last, 1);
        word(32'h0006_0006, 1'b0, 8'd1, 32'h0001_0001, 1'b1);
        data_in_data = 32'h0100_0100;
        data_in_sop = 1'b0;
        data_in_valid = 1'b1;
        #1 chk("address_w2", address, 2);
        @(posedge clk_clk);
        #1 data_in_valid = 1'b0;
        rst_reset = 1'b1;
        #1 chk_all_zero();
        repeat (2) @(posedge clk_clk);
        #1 rst_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_clk);
            #1 chk("flushed", data_out_valid, 0);
        end
        word(32'h0004_0004, 1'b1, 8'd0, 32'h0002_0004, 1'b1);

        // back-to-back words at full throughput
        data_in_data = 32'h0010_0010;
        data_in_sop = 1'b1;
        data_in_valid = 1'b1;
        #1 chk("b2b_addr0", address, 0);
        @(posedge clk_clk);
        #1 data_in_sop = 1'b0;
        #1 chk("b2b_addr1", address, 1);
        @(posedge clk_clk);
        #1 data_in_valid = 1'b0;
        chk("b2b_v0", data_out_valid, 1);
        chk("b2b_d0", data_out_data, 32'h000E_0010);
        chk("b2b_sop0", data_out_sop, 1);
        @(posedge clk_clk);
        #1 chk("b2b_v1", data_out_valid, 1);
        chk("b2b_d1", data_out_data, 32'h000B_000B);
        chk("b2b_sop1", data_out_sop, 0);
        @(posedge clk_clk);
        #1 chk("b2b_idle", data_out_valid, 0);
        chk("b2b_hold", data_out_data, 32'h000B_000B);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
